// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Optional error reporting on ops 12-15 and divide-by-zero: ALU_ARB_ERR_CHECK_EN.
module alu_request_arbiter #(
   parameter int ISSUE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic [15:0] alu_instr,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic        alu_en,
   input  logic [15:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [15:0] rsp_data,
   output logic        rsp_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0] LAST_CNT = 4'(ISSUE_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic        last_q, last_d;
   logic [3:0]  op_q, op_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic        id_q, id_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] data_q, data_d;
   logic        err_q, err_d;

   logic        idle;
   logic        win;
   logic        hs;
   logic [3:0]  sel_op;
   logic [15:0] sel_a;
   logic [15:0] sel_b;
   logic        bad_op;
   logic        div0;

   // Winner: sole valid requester, or the one not granted last on a tie
   always_comb begin
      win = req1_valid;
      if (req0_valid && req1_valid)
         win = ~last_q;
   end

   assign idle       = (state_q == S_IDLE);
   assign req0_ready = idle & req0_valid & ~win;
   assign req1_ready = idle & req1_valid & win;
   assign hs         = req0_ready | req1_ready;
   assign sel_op     = win ? req1_op : req0_op;
   assign sel_a      = win ? req1_a : req0_a;
   assign sel_b      = win ? req1_b : req0_b;

`ifdef ALU_ARB_ERR_CHECK_EN
   assign bad_op = (sel_op[3:2] == 2'b11);
   assign div0   = ((op_q == 4'd3) || (op_q == 4'd4)) && (b_q == 16'd0);
`else
   assign bad_op = 1'b0;
   assign div0   = 1'b0;
`endif

   // Next-state and datapath register updates for IDLE/EXEC/RESP
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (hs) begin
               op_d    = sel_op;
               a_d     = sel_a;
               b_d     = sel_b;
               id_d    = win;
               last_d  = win;
               cnt_d   = 4'd0;
               err_d   = 1'b0;
               state_d = S_EXEC;
               // Undefined ops bypass the ALU entirely
               if (bad_op) begin
                  data_d  = 16'd0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_EXEC: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
               data_d  = alu_result;
               err_d   = div0;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset discards any in-flight op
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         op_q    <= 4'd0;
         a_q     <= 16'd0;
         b_q     <= 16'd0;
         id_q    <= 1'b0;
         cnt_q   <= 4'd0;
         data_q  <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign alu_en    = (state_q == S_EXEC);
   assign alu_instr = alu_en ? {12'h000, op_q} : 16'd0;
   assign alu_a     = alu_en ? a_q : 16'd0;
   assign alu_b     = alu_en ? b_q : 16'd0;
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_id    = id_q;
   assign rsp_data  = data_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Directed bench for alu_request_arbiter: two instances (ISSUE_CYCLES 1 and 3)
// share stimulus; the idle one is held in reset while the other is checked.
module tb_alu_request_arbiter;

`ifdef ALU_ARB_ERR_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic sel = 1'b0;
   logic v0 = 0, v1 = 0;
   logic [3:0] op0 = 0, op1 = 0;
   logic [15:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
   logic rrdy = 0;
   logic [15:0] alu_res;

   logic r0_a, r1_a, en_a, rv_a, id_a, err_a;
   logic [15:0] ins_a, aa_a, ab_a, d_a;
   logic r0_b, r1_b, en_b, rv_b, id_b, err_b;
   logic [15:0] ins_b, aa_b, ab_b, d_b;

   logic s_r0, s_r1, s_en, s_rv, s_id, s_err;
   logic [15:0] s_ins, s_aa, s_ab, s_d;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   alu_request_arbiter #(.ISSUE_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst_a),
      .req0_valid(v0), .req0_ready(r0_a), .req0_op(op0),
      .req0_a(a0), .req0_b(b0),
      .req1_valid(v1), .req1_ready(r1_a), .req1_op(op1),
      .req1_a(a1), .req1_b(b1),
      .alu_instr(ins_a), .alu_a(aa_a), .alu_b(ab_a), .alu_en(en_a),
      .alu_result(alu_res),
      .rsp_valid(rv_a), .rsp_ready(rrdy), .rsp_id(id_a),
      .rsp_data(d_a), .rsp_err(err_a)
   );

   alu_request_arbiter #(.ISSUE_CYCLES(3)) dut_b (
      .clk(clk), .rst(rst_b),
      .req0_valid(v0), .req0_ready(r0_b), .req0_op(op0),
      .req0_a(a0), .req0_b(b0),
      .req1_valid(v1), .req1_ready(r1_b), .req1_op(op1),
      .req1_a(a1), .req1_b(b1),
      .alu_instr(ins_b), .alu_a(aa_b), .alu_b(ab_b), .alu_en(en_b),
      .alu_result(alu_res),
      .rsp_valid(rv_b), .rsp_ready(rrdy), .rsp_id(id_b),
      .rsp_data(d_b), .rsp_err(err_b)
   );

   assign s_r0  = sel ? r0_b  : r0_a;
   assign s_r1  = sel ? r1_b  : r1_a;
   assign s_en  = sel ? en_b  : en_a;
   assign s_rv  = sel ? rv_b  : rv_a;
   assign s_id  = sel ? id_b  : id_a;
   assign s_err = sel ? err_b : err_a;
   assign s_ins = sel ? ins_b : ins_a;
   assign s_aa  = sel ? aa_b  : aa_a;
   assign s_ab  = sel ? ab_b  : ab_a;
   assign s_d   = sel ? d_b   : d_a;

   function automatic logic [15:0] alu_model(
      input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] d;
      logic [31:0] p;
      d = (b == 16'd0) ? 16'd1 : b;
      p = a * b;
      case (op)
         4'd0:  return a << b[3:0];
         4'd1:  return a >> b[3:0];
         4'd2:  return $signed(a) >>> b[3:0];
         4'd3:  return a % d;
         4'd4:  return a / d;
         4'd5:  return p[15:0];
         4'd6:  return a - b;
         4'd7:  return a + b;
         4'd8:  return a & b;
         4'd9:  return a | b;
         4'd10: return a ^ b;
         4'd11: return ~a;
         default: return 16'd0;
      endcase
   endfunction

   assign alu_res = alu_model(s_ins[3:0], s_aa, s_ab);

   task automatic check(input string tag,
                        input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst(input logic which);
      if (which) rst_b = 1'b1; else rst_a = 1'b1;
      tick();
      tick();
      if (which) rst_b = 1'b0; else rst_a = 1'b0;
      #1;
   endtask

   task automatic wait_hs(input logic who, input string tag);
      int k;
      k = 0;
      #1;
      while (!(who ? s_r1 : s_r0) && k < 20) begin
         tick();
         k++;
      end
      check(tag, 32'(who ? s_r1 : s_r0), 32'd1);
   endtask

   task automatic wait_rsp(input string tag);
      int k;
      k = 0;
      while (!s_rv && k < 20) begin
         tick();
         k++;
      end
      check(tag, 32'(s_rv), 32'd1);
   endtask

   task automatic consume();
      rrdy = 1'b1;
      tick();
      rrdy = 1'b0;
      #1;
   endtask

   logic [15:0] exp_d[4];
   logic        exp_id[4];
   logic [15:0] got_d[4];
   logic        got_id[4];

   initial begin
      int n, both, bad, en_cnt, lat;
      // Reset state
      #3;
      check("rst_en",   32'(s_en),  32'd0);
      check("rst_ins",  32'(s_ins), 32'd0);
      check("rst_a",    32'(s_aa),  32'd0);
      check("rst_b",    32'(s_ab),  32'd0);
      check("rst_rv",   32'(s_rv),  32'd0);
      check("rst_id",   32'(s_id),  32'd0);
      check("rst_data", 32'(s_d),   32'd0);
      check("rst_err",  32'(s_err), 32'd0);
      tick();
      rst_a = 1'b0;
      tick();

      // 1: ADD 5+3 on ISSUE_CYCLES=1
      v0 = 1; op0 = 4'd7; a0 = 16'd5; b0 = 16'd3;
      wait_hs(1'b0, "t1_hs");
      check("t1_r1", 32'(s_r1), 32'd0);
      tick();
      v0 = 0;
      check("t1_en",   32'(s_en),  32'd1);
      check("t1_ins",  32'(s_ins), 32'h7);
      check("t1_rv0",  32'(s_rv),  32'd0);
      tick();
      check("t1_rv",   32'(s_rv),  32'd1);
      check("t1_id",   32'(s_id),  32'd0);
      check("t1_data", 32'(s_d),   32'h8);
      check("t1_en0",  32'(s_en),  32'd0);
      check("t1_ins0", 32'(s_ins), 32'd0);
      consume();
      check("t1_rvoff", 32'(s_rv), 32'd0);

      // 2: both valid after reset, grants alternate 0,1,0,1
      pulse_rst(1'b0);
      exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_d  = '{16'h0007, 16'h0014, 16'h0007, 16'h0014};
      v0 = 1; op0 = 4'd6; a0 = 16'd10; b0 = 16'd3;
      v1 = 1; op1 = 4'd5; a1 = 16'd4;  b1 = 16'd5;
      rrdy = 1;
      n = 0; both = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         tick();
         if (s_r0 && s_r1) both++;
         if (s_rv) begin
            got_id[n] = s_id;
            got_d[n]  = s_d;
            n++;
         end
      end
      v0 = 0; v1 = 0; rrdy = 0;
      check("t2_cnt", 32'(n), 32'd4);
      check("t2_both", 32'(both), 32'd0);
      for (int i = 0; i < n; i++) begin
         check($sformatf("t2_id%0d", i), 32'(got_id[i]), 32'(exp_id[i]));
         check($sformatf("t2_d%0d", i),  32'(got_d[i]),  32'(exp_d[i]));
      end

      // 3: response held while rsp_ready low
      pulse_rst(1'b0);
      v0 = 1; op0 = 4'd7; a0 = 16'd1; b0 = 16'd2;
      v1 = 1; op1 = 4'd6; a1 = 16'd9; b1 = 16'd4;
      wait_rsp("t3_rsp");
      for (int i = 0; i < 5; i++) begin
         check("t3_rv", 32'(s_rv), 32'd1);
         check("t3_id", 32'(s_id), 32'd0);
         check("t3_d",  32'(s_d),  32'd3);
         check("t3_rdy", 32'({s_r0, s_r1}), 32'd0);
         tick();
      end
      rrdy = 1;
      #1;
      check("t3_hs_rdy", 32'({s_r0, s_r1}), 32'd0);
      tick();
      rrdy = 0;
      check("t3_rvoff", 32'(s_rv), 32'd0);
      check("t3_r1",    32'(s_r1), 32'd1);
      v0 = 0; v1 = 0;
      #1;

      // 6: XOR on ISSUE_CYCLES=3
      rst_a = 1; sel = 1;
      pulse_rst(1'b1);
      v0 = 1; op0 = 4'd10; a0 = 16'h00FF; b0 = 16'h0F0F;
      wait_hs(1'b0, "t6_hs");
      tick();
      v0 = 0;
      en_cnt = 0; lat = 0;
      for (int i = 0; i < 10; i++) begin
         if (s_rv) break;
         if (s_en) en_cnt++;
         lat++;
         tick();
      end
      check("t6_en_cnt", 32'(en_cnt), 32'd3);
      check("t6_lat",    32'(lat),    32'd3);
      check("t6_data",   32'(s_d),    32'h0FF0);
      check("t6_en_off", 32'(s_en),   32'd0);
      consume();

      // 4: reset mid-EXEC discards op
      pulse_rst(1'b1);
      v1 = 1; op1 = 4'd7; a1 = 16'd2; b1 = 16'd2;
      wait_hs(1'b1, "t4_hs");
      tick();
      v1 = 0;
      check("t4_en", 32'(s_en), 32'd1);
      tick();
      rst_b = 1;
      #1;
      check("t4_en_rst",  32'(s_en),  32'd0);
      check("t4_ins_rst", 32'(s_ins), 32'd0);
      tick();
      rst_b = 0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (s_rv || s_en) bad++;
      end
      check("t4_norsp", 32'(bad), 32'd0);
      v0 = 1; v1 = 1;
      #1;
      check("t4_r0", 32'(s_r0), 32'd1);
      check("t4_r1", 32'(s_r1), 32'd0);
      v0 = 0; v1 = 0;
      #1;

      // 5: DIV by zero and undefined op
      rst_b = 1; sel = 0;
      pulse_rst(1'b0);
      v0 = 1; op0 = 4'd4; a0 = 16'd100; b0 = 16'd0;
      wait_hs(1'b0, "t5_hs");
      tick();
      v0 = 0;
      wait_rsp("t5_rsp");
      check("t5_data", 32'(s_d),   32'h64);
      check("t5_err",  32'(s_err), 32'(ERR_EN));
      consume();
      v0 = 1; op0 = 4'hC; a0 = 16'd1; b0 = 16'd2;
      wait_hs(1'b0, "t5c_hs");
      tick();
      v0 = 0;
`ifdef ALU_ARB_ERR_CHECK_EN
      check("t5c_en",   32'(s_en),  32'd0);
      check("t5c_rv",   32'(s_rv),  32'd1);
      check("t5c_data", 32'(s_d),   32'd0);
      check("t5c_err",  32'(s_err), 32'd1);
`else
      check("t5c_en",   32'(s_en),  32'd1);
      check("t5c_ins",  32'(s_ins), 32'hC);
      tick();
      check("t5c_rv",   32'(s_rv),  32'd1);
      check("t5c_data", 32'(s_d),   32'd0);
      check("t5c_err",  32'(s_err), 32'd0);
`endif
      consume();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=done");
      $fatal(1, "timeout");
   end

endmodule
